// File: rtl/vball_vram_arbiter.sv
// vball_vram_arbiter: shares one single-port synchronous video RAM between
// the tile/sprite fetch pipeline and the CPU. During active fetch, video owns
// three of every four cycles and the CPU owns the fourth. Outside active
// fetch, the CPU owns every cycle.
module vball_vram_arbiter #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [8:0]    hcount,
    input  logic          vb,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    output logic          vid_drop,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_wait,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RDCAP,
        S_ACK,
        S_HOLD
    } state_t;

    state_t state;

    logic vid_slot;
    logic vid_grant;
    logic cpu_grant;

    // Slot decode and cycle ownership. Video and CPU grants are mutually
    // exclusive because a CPU grant requires a non-video slot.
    always_comb begin
        vid_slot  = !vb && (hcount < 9'd256) && (hcount[1:0] != 2'd3);
        vid_grant = vid_slot && vid_req;
        cpu_grant = (state == S_IDLE) && cpu_req && !vid_slot;
    end

    // RAM port mux; the video address is parked on the bus when nobody owns it.
    always_comb begin
        ram_addr = cpu_grant ? cpu_addr : vid_addr;
        ram_we   = cpu_grant && cpu_we;
        ram_din  = cpu_din;
        vid_data = ram_dout;
        cpu_wait = cpu_req && ((state == S_IDLE) || (state == S_RDCAP));
    end

    // Video strobes: valid marks data returning from last cycle's grant,
    // drop flags a request that arrived outside a video slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid <= 1'b0;
            vid_drop  <= 1'b0;
        end else begin
            vid_valid <= vid_grant;
            vid_drop  <= vid_req && !vid_slot;
        end
    end

    // CPU handshake FSM; cpu_ack is registered so it is high exactly while
    // the machine sits in S_ACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cpu_ack  <= 1'b0;
            cpu_dout <= '0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_grant) begin
                        if (cpu_we) begin
                            state   <= S_ACK;
                            cpu_ack <= 1'b1;
                        end else begin
                            state <= S_RDCAP;
                        end
                    end
                end
                S_RDCAP: begin
                    cpu_dout <= ram_dout;
                    cpu_ack  <= 1'b1;
                    state    <= S_ACK;
                end
                S_ACK: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!cpu_req) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vball_vram_arbiter.sv
// Self-checking bench for vball_vram_arbiter with a behavioural synchronous RAM.
module tb_vball_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  hcount;
    logic        vb;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        vid_drop;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic        cpu_ack;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    logic [7:0]  mem [0:8191];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic       drop;
    } vid_exp_t;

    typedef struct {
        logic       rd;
        logic [7:0] d;
    } cpu_exp_t;

    typedef struct {
        logic       vb;
        logic [8:0] hc;
        logic       req;
        logic       ev;
        logic       ed;
    } vec_t;

    vid_exp_t vq[$];
    cpu_exp_t cq[$];

    vball_vram_arbiter #(.AW(13), .DW(8)) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vb(vb),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
        .vid_data(vid_data), .vid_drop(vid_drop),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .cpu_ack(cpu_ack), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; registered video outputs now reflect the previous cycle.
    task automatic next_cycle();
        vid_exp_t e;
        @(posedge clk);
        #1;
        if (vq.size() > 0) begin
            e = vq.pop_front();
            chk("vid_valid", 32'(vid_valid), 32'(e.valid));
            chk("vid_drop", 32'(vid_drop), 32'(e.drop));
        end
    endtask

    // Let freshly driven inputs settle; any ack must match a pending transaction.
    task automatic settle();
        cpu_exp_t e;
        #1;
        if (cpu_ack === 1'b1) begin
            chk("ack_pending", 32'(cq.size() > 0), 32'd1);
            if (cq.size() > 0) begin
                e = cq.pop_front();
                if (e.rd) chk("cpu_dout", 32'(cpu_dout), 32'(e.d));
            end
        end
    endtask

    // One complete CPU access during vertical blank, released right after ack.
    task automatic cpu_access(input logic we, input logic [12:0] a, input logic [7:0] d,
                              input logic [7:0] exp);
        int lat;
        lat = we ? 1 : 2;
        for (int c = 0; c <= lat + 1; c++) begin
            next_cycle();
            vb = 1'b1; hcount = 9'd0; vid_req = 1'b0; vid_addr = 13'h1FFF;
            cpu_req = (c <= lat); cpu_we = we; cpu_addr = a; cpu_din = d;
            if (c == 0) cq.push_back('{rd: !we, d: exp});
            settle();
            if (c == 0) begin
                chk("acc_grant_addr", 32'(ram_addr), 32'(a));
                chk("acc_grant_we", 32'(ram_we), 32'(we));
            end
            chk("acc_ack", 32'(cpu_ack), 32'(c == lat));
        end
        next_cycle();
    endtask

    vec_t vec[15];
    logic [1:0] req6 [7];
    int ack_cnt;
    int we_cnt;

    initial begin
        vec[0]  = '{vb: 0, hc: 9'd0,   req: 1, ev: 1, ed: 0};
        vec[1]  = '{vb: 0, hc: 9'd1,   req: 1, ev: 1, ed: 0};
        vec[2]  = '{vb: 0, hc: 9'd2,   req: 1, ev: 1, ed: 0};
        vec[3]  = '{vb: 0, hc: 9'd3,   req: 0, ev: 0, ed: 0};
        vec[4]  = '{vb: 0, hc: 9'd4,   req: 1, ev: 1, ed: 0};
        vec[5]  = '{vb: 0, hc: 9'd5,   req: 1, ev: 1, ed: 0};
        vec[6]  = '{vb: 0, hc: 9'd6,   req: 1, ev: 1, ed: 0};
        vec[7]  = '{vb: 0, hc: 9'd7,   req: 0, ev: 0, ed: 0};
        vec[8]  = '{vb: 0, hc: 9'd0,   req: 0, ev: 0, ed: 0};
        vec[9]  = '{vb: 0, hc: 9'd252, req: 1, ev: 1, ed: 0};
        vec[10] = '{vb: 0, hc: 9'd256, req: 1, ev: 0, ed: 1};
        vec[11] = '{vb: 0, hc: 9'd384, req: 1, ev: 0, ed: 1};
        vec[12] = '{vb: 1, hc: 9'd0,   req: 1, ev: 0, ed: 1};
        vec[13] = '{vb: 1, hc: 9'd5,   req: 1, ev: 0, ed: 1};
        vec[14] = '{vb: 0, hc: 9'd1,   req: 1, ev: 1, ed: 0};

        reset = 1'b1; hcount = '0; vb = 1'b0; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        #2;
        chk("rst_vid_valid", 32'(vid_valid), 32'd0);
        chk("rst_vid_drop", 32'(vid_drop), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Video slot table.
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            vb = vec[i].vb; hcount = vec[i].hc; vid_req = vec[i].req;
            vid_addr = 13'h1000 + 13'(i);
            vq.push_back('{valid: vec[i].ev, drop: vec[i].ed});
            settle();
            if (vec[i].ev) chk("vid_ram_addr", 32'(ram_addr), 32'(vid_addr));
            chk("vid_ram_we", 32'(ram_we), 32'd0);
        end
        next_cycle();

        // CPU write waits for the fourth slot.
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            vb = 1'b0; hcount = 9'(c); vid_req = 1'b0; vid_addr = 13'h0AAA;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0123; cpu_din = 8'h5A;
            if (c == 0) cq.push_back('{rd: 1'b0, d: 8'h00});
            settle();
            chk("wr_ram_we", 32'(ram_we), 32'(c == 3));
            chk("wr_cpu_wait", 32'(cpu_wait), 32'(c <= 3));
            chk("wr_cpu_ack", 32'(cpu_ack), 32'(c == 4));
            if (c == 3) chk("wr_ram_addr", 32'(ram_addr), 32'h0123);
        end
        next_cycle();
        cpu_req = 1'b0;
        settle();
        next_cycle();

        // Preload 0x0040 = 0xC3 through the CPU port.
        cpu_access(1'b1, 13'h0040, 8'hC3, 8'h00);

        // Read in vertical blank, held for five extra cycles.
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            vb = 1'b1; hcount = 9'd0; vid_req = 1'b0; vid_addr = 13'h1FFF;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040;
            if (c == 0) cq.push_back('{rd: 1'b1, d: 8'hC3});
            settle();
            if (c == 0) chk("rd_grant_addr", 32'(ram_addr), 32'h0040);
            if (c >= 3) chk("rd_no_reissue", 32'(ram_addr), 32'h1FFF);
            chk("rd_cpu_ack", 32'(cpu_ack), 32'(c == 2));
            chk("rd_cpu_wait", 32'(cpu_wait), 32'(c <= 1));
        end
        next_cycle();
        cpu_req = 1'b0;
        settle();
        next_cycle();

        // Video requests beyond the active region drop; CPU read granted at once.
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            vb = 1'b0; hcount = 9'(300 + c); vid_addr = 13'h0555;
            vid_req = (c < 3); cpu_req = (c < 3); cpu_we = 1'b0; cpu_addr = 13'h0040;
            vq.push_back('{valid: 1'b0, drop: (c < 3)});
            if (c == 0) cq.push_back('{rd: 1'b1, d: 8'hC3});
            settle();
            if (c == 0) chk("drop_cpu_grant", 32'(ram_addr), 32'h0040);
            chk("drop_cpu_ack", 32'(cpu_ack), 32'(c == 2));
        end
        next_cycle();
        next_cycle();

        // Reset in the capture cycle of a read granted at hcount 255.
        next_cycle();
        vb = 1'b0; hcount = 9'd255; vid_req = 1'b0; vid_addr = 13'h0AAA;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0123;
        settle();
        chk("rst5_grant_addr", 32'(ram_addr), 32'h0123);
        next_cycle();
        hcount = 9'd256;
        reset = 1'b1;
        settle();
        chk("rst5_ack", 32'(cpu_ack), 32'd0);
        chk("rst5_dout", 32'(cpu_dout), 32'd0);
        next_cycle();
        cpu_req = 1'b0;
        settle();
        chk("rst5_ack_hold", 32'(cpu_ack), 32'd0);
        next_cycle();
        reset = 1'b0;
        settle();
        chk("rst5_wait", 32'(cpu_wait), 32'd0);
        chk("rst5_dout_after", 32'(cpu_dout), 32'd0);
        cpu_access(1'b0, 13'h0123, 8'h00, 8'h5A);

        // Back-to-back writes separated by one idle request cycle.
        req6 = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        ack_cnt = 0;
        we_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            vb = 1'b1; hcount = 9'd100; vid_req = 1'b0; vid_addr = 13'h1FFF;
            cpu_req = req6[c][0]; cpu_we = 1'b1;
            cpu_addr = (c < 3) ? 13'h0200 : 13'h0201;
            cpu_din = (c < 3) ? 8'h11 : 8'h22;
            if (c == 0 || c == 3) cq.push_back('{rd: 1'b0, d: 8'h00});
            settle();
            chk("b2b_ram_we", 32'(ram_we), 32'(c == 0 || c == 3));
            if (cpu_ack) ack_cnt++;
            if (ram_we) we_cnt++;
        end
        chk("b2b_ack_count", 32'(ack_cnt), 32'd2);
        chk("b2b_we_count", 32'(we_cnt), 32'd2);
        cpu_access(1'b0, 13'h0200, 8'h00, 8'h11);
        cpu_access(1'b0, 13'h0201, 8'h00, 8'h22);

        chk("acks_outstanding", 32'(cq.size()), 32'd0);
        chk("vid_outstanding", 32'(vq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
